// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns stage: loads a 128-bit state on En, transforms one
// column per clock, then holds the result with Ry until En is released.
// Optional feature macro: MXC_INVERSE_EN (adds Dec port and InvMixColumns).
module mix_columns_iter (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         En,
  input  logic [127:0] Text,
`ifdef MXC_INVERSE_EN
  input  logic         Dec,
`endif
  output logic [127:0] Text_MXC,
  output logic         Ry
);

  localparam int unsigned STATE_W = 128;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned CNT_W   = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [STATE_W-1:0]   r_work;
  logic [STATE_W-1:0]   r_text_mxc;
  logic                 r_ry;
  logic [STATE_W-1:0]   w_work_nxt;
  logic [BYTE_W-1:0]    w_a [4];
  logic [BYTE_W-1:0]    w_b [4];
  logic                 w_load;
  logic                 w_step;
  logic                 w_finish;
  logic                 w_release;
`ifdef MXC_INVERSE_EN
  logic                 r_dec;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

`ifdef MXC_INVERSE_EN
  function automatic logic [7:0] mul9(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ x;
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
  endfunction
`endif

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (En) w_state_nxt = S_CALC;
      S_CALC:  if (r_cnt == CNT_W'(3)) w_state_nxt = S_DONE;
      S_DONE:  if (!En) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath control strobes decoded from the current state
  always_comb begin
    w_load    = 1'b0;
    w_step    = 1'b0;
    w_finish  = 1'b0;
    w_release = 1'b0;
    case (r_state)
      S_IDLE: w_load = En;
      S_CALC: begin
        w_step   = 1'b1;
        w_finish = (r_cnt == CNT_W'(3));
      end
      S_DONE:  w_release = !En;
      default: ;
    endcase
  end

  // Transform the column selected by r_cnt and splice it back into the state
  always_comb begin
    w_work_nxt = r_work;
    for (int r = 0; r < 4; r++) begin
      w_a[r] = r_work[(STATE_W - 1) - 32 * r - 8 * int'(r_cnt) -: BYTE_W];
    end
    w_b[0] = xtime(w_a[0]) ^ mul3(w_a[1]) ^ w_a[2] ^ w_a[3];
    w_b[1] = w_a[0] ^ xtime(w_a[1]) ^ mul3(w_a[2]) ^ w_a[3];
    w_b[2] = w_a[0] ^ w_a[1] ^ xtime(w_a[2]) ^ mul3(w_a[3]);
    w_b[3] = mul3(w_a[0]) ^ w_a[1] ^ w_a[2] ^ xtime(w_a[3]);
`ifdef MXC_INVERSE_EN
    if (r_dec) begin
      w_b[0] = mul14(w_a[0]) ^ mul11(w_a[1]) ^ mul13(w_a[2]) ^ mul9(w_a[3]);
      w_b[1] = mul9(w_a[0]) ^ mul14(w_a[1]) ^ mul11(w_a[2]) ^ mul13(w_a[3]);
      w_b[2] = mul13(w_a[0]) ^ mul9(w_a[1]) ^ mul14(w_a[2]) ^ mul11(w_a[3]);
      w_b[3] = mul11(w_a[0]) ^ mul13(w_a[1]) ^ mul9(w_a[2]) ^ mul14(w_a[3]);
    end
`endif
    for (int r = 0; r < 4; r++) begin
      w_work_nxt[(STATE_W - 1) - 32 * r - 8 * int'(r_cnt) -: BYTE_W] = w_b[r];
    end
  end

  // Work register, column counter and registered outputs
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_work     <= '0;
      r_cnt      <= '0;
      r_text_mxc <= '0;
      r_ry       <= 1'b0;
`ifdef MXC_INVERSE_EN
      r_dec      <= 1'b0;
`endif
    end else begin
      if (w_load) begin
        r_work <= Text;
        r_cnt  <= '0;
`ifdef MXC_INVERSE_EN
        r_dec  <= Dec;
`endif
      end
      if (w_step) begin
        r_work <= w_work_nxt;
        r_cnt  <= r_cnt + CNT_W'(1);
      end
      if (w_finish) begin
        r_text_mxc <= w_work_nxt;
        r_ry       <= 1'b1;
      end
      if (w_release) r_ry <= 1'b0;
    end
  end

  assign Text_MXC = r_text_mxc;
  assign Ry       = r_ry;

endmodule
